multdiv_scheduler: RTL and testbench

- Sequences the shared multiply/divide unit that sits beside the X stage and writes back through the P/W latch.
- Captures a mul/div leaving DX, issues a one-cycle start pulse to the unit, and counts cycles until the unit reports ready or a timeout expires.
- Stalls the D stage on hazards against the pending destination register.
- Arbitrates the single regfile write port: MW has priority, and the multdiv result waits.

---
 rtl/multdiv_scheduler.sv | 114 +++++++++++
 tb/tb_multdiv_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_scheduler.sv
// Sequencer for the shared multiply/divide unit beside X: start pulse, cycle count,
// D-stage hazard stall and arbitration of the regfile write port against MW.
module multdiv_scheduler #(
  parameter int         TIMEOUT = 40,
  parameter int         CNT_W   = 6,
  parameter logic [4:0] EXC_REG = 5'd30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       x_valid,
  input  logic       x_is_mul,
  input  logic       x_is_div,
  input  logic [4:0] x_rd,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_uses_rs,
  input  logic       d_uses_rt,
  input  logic       d_writes,
  input  logic [4:0] d_rd,
  input  logic       d_is_md,
  input  logic       md_ready,
  input  logic       md_exception,
  input  logic       mw_we,
  output logic       ctrl_mult,
  output logic       ctrl_div,
  output logic       busy,
  output logic       stall_d,
  output logic       p_we,
  output logic [4:0] p_rd,
  output logic       p_exc,
  output logic       err_overlap
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             op_mul_q;
  logic [4:0]       rd_q;
  logic             exc_q;
  logic             err_q;

  logic       start;
  logic       in_wb;
  logic [4:0] pending_rd;
  logic       hazard;

  assign start = x_valid & (x_is_mul | x_is_div);
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
      rd_q     <= '0;
      exc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            op_mul_q <= x_is_mul;
            rd_q     <= x_rd;
            exc_q    <= 1'b0;
          end
        end
        RUN: begin
          if (start) err_q <= 1'b1;
          cnt_q <= cnt_d;
          // A ready result beats the timeout when both land on the same cycle.
          if (md_ready) begin
            exc_q   <= md_exception;
            state_q <= WB;
          end else if (cnt_q == LAST_CNT) begin
            exc_q   <= 1'b1;
            state_q <= WB;
          end
        end
        WB: begin
          if (start) err_q <= 1'b1;
          if (!mw_we) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign in_wb      = (state_q == WB);
  assign pending_rd = exc_q ? EXC_REG : rd_q;

  assign ctrl_mult = (state_q == RUN) && (cnt_q == '0) && op_mul_q;
  assign ctrl_div  = (state_q == RUN) && (cnt_q == '0) && !op_mul_q;

  // r0 is never a real dependency, so a zero pending destination raises no hazard.
  assign hazard = (pending_rd != 5'd0) &&
                  ((d_uses_rs && (d_rs == pending_rd)) ||
                   (d_uses_rt && (d_rt == pending_rd)) ||
                   (d_writes  && (d_rd == pending_rd)));

  assign stall_d = busy && (hazard || d_is_md);

  assign p_we        = in_wb && !mw_we && (exc_q || (rd_q != 5'd0));
  assign p_rd        = in_wb ? pending_rd : 5'd0;
  assign p_exc       = in_wb && exc_q;
  assign err_overlap = err_q;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Self-checking bench for multdiv_scheduler: a behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_multdiv_scheduler;

  localparam int TIMEOUT = 40;
  localparam logic [4:0] EXC_REG = 5'd30;

  logic       clock;
  logic       reset;
  logic       x_valid, x_is_mul, x_is_div;
  logic [4:0] x_rd;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       d_uses_rs, d_uses_rt, d_writes, d_is_md;
  logic       md_ready, md_exception, mw_we;
  logic       ctrl_mult, ctrl_div, busy, stall_d, p_we, p_exc, err_overlap;
  logic [4:0] p_rd;

  int checks = 0;
  int errors = 0;

  multdiv_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(6), .EXC_REG(EXC_REG)) dut (
    .clock(clock), .reset(reset),
    .x_valid(x_valid), .x_is_mul(x_is_mul), .x_is_div(x_is_div), .x_rd(x_rd),
    .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .d_writes(d_writes), .d_rd(d_rd), .d_is_md(d_is_md),
    .md_ready(md_ready), .md_exception(md_exception), .mw_we(mw_we),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .busy(busy), .stall_d(stall_d),
    .p_we(p_we), .p_rd(p_rd), .p_exc(p_exc), .err_overlap(err_overlap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: phase 0 = no operation, 1 = waiting on the unit, 2 = holding a result.
  int         mPhase = 0;
  int         mRunCycles = 0;
  logic       mMul = 1'b0;
  logic [4:0] mRd = '0;
  logic       mExc = 1'b0;
  logic       mErr = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mPhase = 0; mRunCycles = 0; mMul = 1'b0; mRd = '0; mExc = 1'b0; mErr = 1'b0;
    end else begin
      automatic logic startNow = x_valid && (x_is_mul || x_is_div);
      if (mPhase != 0 && startNow) mErr = 1'b1;
      if (mPhase == 0) begin
        if (startNow) begin
          mPhase = 1; mRunCycles = 0; mMul = x_is_mul; mRd = x_rd; mExc = 1'b0;
        end
      end else if (mPhase == 1) begin
        mRunCycles = mRunCycles + 1;
        if (md_ready) begin
          mExc = md_exception; mPhase = 2;
        end else if (mRunCycles == TIMEOUT) begin
          mExc = 1'b1; mPhase = 2;
        end
      end else begin
        if (!mw_we) mPhase = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    automatic logic [4:0] pend = mExc ? EXC_REG : mRd;
    automatic logic haz = (pend != 0) && ((d_uses_rs && d_rs == pend) ||
                          (d_uses_rt && d_rt == pend) || (d_writes && d_rd == pend));
    automatic logic expBusy = (mPhase != 0);
    automatic logic expWb = (mPhase == 2);
    checkOutput("model_busy", 32'(busy), 32'(expBusy));
    checkOutput("model_ctrl_mult", 32'(ctrl_mult), 32'(mPhase == 1 && mRunCycles == 0 && mMul));
    checkOutput("model_ctrl_div", 32'(ctrl_div), 32'(mPhase == 1 && mRunCycles == 0 && !mMul));
    checkOutput("model_stall_d", 32'(stall_d), 32'(expBusy && (haz || d_is_md)));
    checkOutput("model_p_we", 32'(p_we), 32'(expWb && !mw_we && (mExc || mRd != 0)));
    checkOutput("model_p_rd", 32'(p_rd), 32'(expWb ? pend : 5'd0));
    checkOutput("model_p_exc", 32'(p_exc), 32'(expWb && mExc));
    checkOutput("model_err_overlap", 32'(err_overlap), 32'(mErr));
  end

  task automatic applyStimulus(input logic v, input logic mul, input logic dv, input logic [4:0] rd);
    x_valid = v; x_is_mul = mul; x_is_div = dv; x_rd = rd;
  endtask

  task automatic clearD();
    d_rs = '0; d_rt = '0; d_rd = '0;
    d_uses_rs = 1'b0; d_uses_rt = 1'b0; d_writes = 1'b0; d_is_md = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int pulses;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    clearD();
    md_ready = 1'b0; md_exception = 1'b0; mw_we = 1'b0;
    tick(); tick();
    settle();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err_overlap), 32'd0);
    checkOutput("reset_p_rd", 32'(p_rd), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] mul rd=5, ready at cnt=3");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    settle();
    checkOutput("t1_ctrl_mult_first", 32'(ctrl_mult), 32'd1);
    tick(); settle();
    checkOutput("t1_ctrl_mult_second", 32'(ctrl_mult), 32'd0);
    tick(); tick();
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    settle();
    checkOutput("t1_p_we", 32'(p_we), 32'd1);
    checkOutput("t1_p_rd", 32'(p_rd), 32'd5);
    checkOutput("t1_p_exc", 32'(p_exc), 32'd0);
    tick(); settle();
    checkOutput("t1_busy_after", 32'(busy), 32'd0);

    $display("[TB] div rd=7 with exception, D reads r30 during writeback");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    md_ready = 1'b1; md_exception = 1'b1;
    settle();
    checkOutput("t2_ctrl_div", 32'(ctrl_div), 32'd1);
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    d_uses_rs = 1'b1; d_rs = 5'd30;
    settle();
    checkOutput("t2_p_we", 32'(p_we), 32'd1);
    checkOutput("t2_p_rd", 32'(p_rd), 32'd30);
    checkOutput("t2_p_exc", 32'(p_exc), 32'd1);
    checkOutput("t2_stall", 32'(stall_d), 32'd1);
    tick(); settle();
    checkOutput("t2_stall_released", 32'(stall_d), 32'd0);
    clearD();

    $display("[TB] mul rd=9 timeout");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd9);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    pulses = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      if (ctrl_mult) pulses++;
      if (i == TIMEOUT - 1) checkOutput("t3_busy_last_run", 32'(busy), 32'd1);
      tick();
    end
    settle();
    checkOutput("t3_pulses", 32'(pulses), 32'd1);
    checkOutput("t3_p_we", 32'(p_we), 32'd1);
    checkOutput("t3_p_rd", 32'(p_rd), 32'd30);
    checkOutput("t3_p_exc", 32'(p_exc), 32'd1);
    tick();

    $display("[TB] result blocked by MW for three cycles");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd12);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    md_ready = 1'b1; mw_we = 1'b1;
    d_uses_rt = 1'b1; d_rt = 5'd12;
    tick();
    md_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("t4_p_we_blocked", 32'(p_we), 32'd0);
      checkOutput("t4_busy_blocked", 32'(busy), 32'd1);
      checkOutput("t4_stall_blocked", 32'(stall_d), 32'd1);
      tick();
    end
    mw_we = 1'b0;
    settle();
    checkOutput("t4_p_we_fourth", 32'(p_we), 32'd1);
    checkOutput("t4_p_rd", 32'(p_rd), 32'd12);
    tick();
    clearD();

    $display("[TB] hazard patterns with pending rd=4");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    d_uses_rs = 1'b1; d_rs = 5'd4;
    settle(); checkOutput("t5_read_r4", 32'(stall_d), 32'd1);
    tick(); clearD();
    d_uses_rs = 1'b1; d_rs = 5'd3; d_rt = 5'd4;
    settle(); checkOutput("t5_read_r3", 32'(stall_d), 32'd0);
    tick(); clearD();
    d_writes = 1'b1; d_rd = 5'd4;
    settle(); checkOutput("t5_write_r4", 32'(stall_d), 32'd1);
    tick(); clearD();
    d_is_md = 1'b1;
    settle(); checkOutput("t5_fd_md", 32'(stall_d), 32'd1);
    tick(); clearD();
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    settle(); checkOutput("t5_p_rd", 32'(p_rd), 32'd4);
    tick();

    $display("[TB] pending rd=0");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    d_uses_rs = 1'b1; d_uses_rt = 1'b1;
    settle(); checkOutput("t5_r0_stall", 32'(stall_d), 32'd0);
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    settle(); checkOutput("t5_r0_no_we", 32'(p_we), 32'd0);
    tick(); settle();
    checkOutput("t5_r0_idle", 32'(busy), 32'd0);
    clearD();

    $display("[TB] start on the writeback-to-idle cycle");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd11);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    settle();
    checkOutput("t6_wb_overlap_idle", 32'(busy), 32'd0);
    checkOutput("t6_wb_overlap_err", 32'(err_overlap), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t6_err_cleared", 32'(err_overlap), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] start while running, then reset mid-run");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd4);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd8);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    settle();
    checkOutput("t6_run_err", 32'(err_overlap), 32'd1);
    checkOutput("t6_no_div_pulse", 32'(ctrl_div), 32'd0);
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    settle();
    checkOutput("t6_rd_kept", 32'(p_rd), 32'd4);
    checkOutput("t6_err_held", 32'(err_overlap), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd6);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    d_uses_rs = 1'b1; d_rs = 5'd6;
    settle();
    reset = 1'b0;
    #1;
    checkOutput("t7_rst_busy", 32'(busy), 32'd0);
    checkOutput("t7_rst_stall", 32'(stall_d), 32'd0);
    checkOutput("t7_rst_err", 32'(err_overlap), 32'd0);
    checkOutput("t7_rst_ctrl", 32'(ctrl_mult), 32'd0);
    tick();
    reset = 1'b1;
    md_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("t7_no_we_after", 32'(p_we), 32'd0);
      tick();
    end
    md_ready = 1'b0;
    clearD();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
